// File: rtl/quad_decoder_multi_if.sv
// Pin/register-side bundle for quad_decoder_multi.
// The idx index input exists only when QUAD_DECODER_INDEX_EN is defined.
interface quad_decoder_multi_if #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 8
);
  logic [NCH-1:0]       x;
  logic [NCH-1:0]       y;
  logic [NCH-1:0]       clr;
  logic [NCH-1:0]       err_clr;
`ifdef QUAD_DECODER_INDEX_EN
  logic [NCH-1:0]       idx;
`endif
  logic [NCH*CNT_W-1:0] counter;
  logic [NCH-1:0]       dir;
  logic [NCH-1:0]       step;
  logic [NCH-1:0]       err;

  modport master (
    output x, y, clr, err_clr,
`ifdef QUAD_DECODER_INDEX_EN
    output idx,
`endif
    input  counter, dir, step, err
  );

  modport slave (
    input  x, y, clr, err_clr,
`ifdef QUAD_DECODER_INDEX_EN
    input  idx,
`endif
    output counter, dir, step, err
  );
endinterface

// File: rtl/quad_decoder_multi.sv
// Multi-channel quadrature decoder: sync, glitch filter, Gray decode, up/down counter.
// Optional index-pulse counter reset is enabled by defining QUAD_DECODER_INDEX_EN.
module quad_decoder_multi #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned DECODE   = 4,
  parameter int unsigned SAT      = 0
) (
  input  logic               clk,
  input  logic               reset,
  quad_decoder_multi_if.slave bus
);

  localparam int unsigned FW = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Forward Gray order of {x,y}: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] gray_fwd(input logic [1:0] v);
    logic [1:0] r;
    case (v)
      2'b00:   r = 2'b10;
      2'b10:   r = 2'b11;
      2'b11:   r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  logic [NCH-1:0][CNT_W-1:0] cnt_w;
  logic [NCH-1:0]            dir_w;
  logic [NCH-1:0]            step_w;
  logic [NCH-1:0]            err_w;

  assign bus.counter = cnt_w;
  assign bus.dir     = dir_w;
  assign bus.step    = step_w;
  assign bus.err     = err_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]       sync1_q, sync1_d, s_q, s_d, prev_q, prev_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [1:0]       f_q, f_d;
    logic             fupd_q, fupd_d;
    logic [1:0]       ref_q, ref_d;
    logic             rv_q, rv_d;
    logic             up_q, up_d, dn_q, dn_d;
    logic             cup_q, cup_d, cdn_q, cdn_d;
    logic             bad_q, bad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic             load_zero;
`ifdef QUAD_DECODER_INDEX_EN
    logic             isync1_q, isync1_d, is_q, is_d, iprev_q, iprev_d;
    logic [FW-1:0]    ifcnt_q, ifcnt_d;
    logic             if_q, if_d;
    logic             irise_q, irise_d;
`endif

    always_comb begin
      sync1_d = {bus.x[i], bus.y[i]};
      s_d     = sync1_q;
      prev_d  = s_q;
      fcnt_d  = fcnt_q;
      f_d     = f_q;
      fupd_d  = 1'b0;
      // Without a reference every stable sample counts as a change so the first one gets loaded
      if ((s_q != f_q) || !rv_q) begin
        fcnt_d = (s_q == prev_q) ? fcnt_q + FW'(1) : FW'(1);
        if (fcnt_d >= FW'(FILT_LEN)) begin
          f_d    = s_q;
          fupd_d = 1'b1;
          fcnt_d = '0;
        end
      end else begin
        fcnt_d = '0;
      end

      ref_d = ref_q;
      rv_d  = rv_q;
      up_d  = 1'b0;
      dn_d  = 1'b0;
      cup_d = 1'b0;
      cdn_d = 1'b0;
      bad_d = 1'b0;
      if (fupd_q) begin
        ref_d = f_q;
        rv_d  = 1'b1;
        if (rv_q && (f_q != ref_q)) begin
          if (f_q == gray_fwd(ref_q)) begin
            up_d  = 1'b1;
            cup_d = (DECODE == 1) ? (ref_q == 2'b01) : 1'b1;
          end else if (gray_fwd(f_q) == ref_q) begin
            dn_d  = 1'b1;
            cdn_d = (DECODE == 1) ? (ref_q == 2'b00) : 1'b1;
          end else begin
            bad_d = 1'b1;
          end
        end
      end

`ifdef QUAD_DECODER_INDEX_EN
      isync1_d = bus.idx[i];
      is_d     = isync1_q;
      iprev_d  = is_q;
      ifcnt_d  = ifcnt_q;
      if_d     = if_q;
      irise_d  = 1'b0;
      if (is_q != if_q) begin
        ifcnt_d = (is_q == iprev_q) ? ifcnt_q + FW'(1) : FW'(1);
        if (ifcnt_d >= FW'(FILT_LEN)) begin
          if_d    = is_q;
          irise_d = is_q;
          ifcnt_d = '0;
        end
      end else begin
        ifcnt_d = '0;
      end
      load_zero = bus.clr[i] | irise_q;
`else
      load_zero = bus.clr[i];
`endif

      dir_d = up_q ? 1'b1 : (dn_q ? 1'b0 : dir_q);
      err_d = bad_q | (err_q & ~bus.err_clr[i]);

      // clr/index take priority over a pending count; step only on an actual value change
      cnt_d = cnt_q;
      if (load_zero) begin
        cnt_d = '0;
      end else if (cup_q) begin
        if (!((SAT != 0) && (cnt_q == CNT_MAX))) cnt_d = cnt_q + CNT_W'(1);
      end else if (cdn_q) begin
        if (!((SAT != 0) && (cnt_q == '0))) cnt_d = cnt_q - CNT_W'(1);
      end
      step_d = (cnt_d != cnt_q);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= '0;
        s_q     <= '0;
        prev_q  <= '0;
        fcnt_q  <= '0;
        f_q     <= '0;
        fupd_q  <= 1'b0;
        ref_q   <= '0;
        rv_q    <= 1'b0;
        up_q    <= 1'b0;
        dn_q    <= 1'b0;
        cup_q   <= 1'b0;
        cdn_q   <= 1'b0;
        bad_q   <= 1'b0;
        cnt_q   <= '0;
        dir_q   <= 1'b0;
        step_q  <= 1'b0;
        err_q   <= 1'b0;
`ifdef QUAD_DECODER_INDEX_EN
        isync1_q <= 1'b0;
        is_q     <= 1'b0;
        iprev_q  <= 1'b0;
        ifcnt_q  <= '0;
        if_q     <= 1'b0;
        irise_q  <= 1'b0;
`endif
      end else begin
        sync1_q <= sync1_d;
        s_q     <= s_d;
        prev_q  <= prev_d;
        fcnt_q  <= fcnt_d;
        f_q     <= f_d;
        fupd_q  <= fupd_d;
        ref_q   <= ref_d;
        rv_q    <= rv_d;
        up_q    <= up_d;
        dn_q    <= dn_d;
        cup_q   <= cup_d;
        cdn_q   <= cdn_d;
        bad_q   <= bad_d;
        cnt_q   <= cnt_d;
        dir_q   <= dir_d;
        step_q  <= step_d;
        err_q   <= err_d;
`ifdef QUAD_DECODER_INDEX_EN
        isync1_q <= isync1_d;
        is_q     <= is_d;
        iprev_q  <= iprev_d;
        ifcnt_q  <= ifcnt_d;
        if_q     <= if_d;
        irise_q  <= irise_d;
`endif
      end
    end

    assign cnt_w[i]  = cnt_q;
    assign dir_w[i]  = dir_q;
    assign step_w[i] = step_q;
    assign err_w[i]  = err_q;
  end

endmodule
